// File: rtl/uart_rx.sv
// uart_rx: serial UART receiver, frame-compatible with uart_tx.
// Synchronises rx_i, detects the start bit, samples each bit at mid-period, checks parity and
// stop bits and hands good bytes to a consumer through a one-entry valid/ready holding register.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   rx_i         serial line, idle high, asynchronous to clk_i
//   rx_data_o    received byte, LSB first on the line, unused upper bits read 0
//   rx_valid_o   rx_data_o holds an unconsumed byte
//   rx_ready_i   consumer accepts the byte when rx_valid_o & rx_ready_i
//   busy_o       receiver is inside a frame
//   frame_err_o  1-cycle pulse, stop bit sampled low
//   parity_err_o 1-cycle pulse, parity bit mismatch
//   overrun_o    1-cycle pulse, good byte lost because the holding register was full
module uart_rx #(
  parameter logic [15:0] CFG_BAUD_DIV    = 16'h55,
  parameter logic [2:0]  CFG_TARGET_BITS = 3'h7,
  parameter logic        CFG_PARITY_EN   = 1'b0,
  parameter logic [1:0]  CFG_PARITY_SEL  = 2'h0,
  parameter logic        CFG_STOP_BITS   = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o
);

  localparam logic [15:0] HalfDiv = CFG_BAUD_DIV >> 1;

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop1, StStop2, StDone
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rxs_q, rxs_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_acc_q, par_acc_d;
  logic        par_bad_q, par_bad_d;
  logic        stop_bad_q, stop_bad_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        parity_err_q, parity_err_d;
  logic        overrun_q, overrun_d;

  logic        start_edge, sample_pt, par_exp, pop, good;
  logic [15:0] cnt_target;

  assign start_edge = rxs_prev_q & ~rxs_q;
  // Start bit is checked at its centre; every later bit one full period after the previous sample.
  assign cnt_target = (state_q == StStart) ? HalfDiv : CFG_BAUD_DIV;
  assign sample_pt  = (cnt_q == cnt_target);

  // par_acc_q holds the XOR of all data bits once the parity bit is reached.
  always_comb begin
    case (CFG_PARITY_SEL)
      2'b00:   par_exp = ~par_acc_q;
      2'b01:   par_exp = par_acc_q;
      2'b10:   par_exp = 1'b0;
      default: par_exp = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    if (state_q == StIdle || state_q == StDone || sample_pt) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d    = StStart;
          bit_cnt_d  = '0;
          par_acc_d  = 1'b0;
          par_bad_d  = 1'b0;
          stop_bad_d = 1'b0;
        end
      end
      StStart: begin
        // A line that is high again at the start centre was a glitch: drop it silently.
        if (sample_pt) state_d = rxs_q ? StIdle : StData;
      end
      StData: begin
        if (sample_pt) begin
          shift_d   = {rxs_q, shift_q[7:1]};
          par_acc_d = par_acc_q ^ rxs_q;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == CFG_TARGET_BITS) state_d = CFG_PARITY_EN ? StParity : StStop1;
        end
      end
      StParity: begin
        if (sample_pt) begin
          par_bad_d = (rxs_q != par_exp);
          state_d   = StStop1;
        end
      end
      StStop1: begin
        if (sample_pt) begin
          stop_bad_d = ~rxs_q;
          state_d    = CFG_STOP_BITS ? StStop2 : StDone;
        end
      end
      StStop2: begin
        if (sample_pt) begin
          stop_bad_d = stop_bad_q | ~rxs_q;
          state_d    = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Holding register: a pop in the same cycle as a new good byte frees the slot for it.
  always_comb begin
    pop          = rx_valid_q & rx_ready_i;
    good         = (state_q == StDone) & ~stop_bad_q & ~par_bad_q;
    frame_err_d  = (state_q == StDone) & stop_bad_q;
    parity_err_d = (state_q == StDone) & ~stop_bad_q & par_bad_q;
    overrun_d    = good & rx_valid_q & ~pop;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    if (pop) rx_valid_d = 1'b0;
    if (good && (!rx_valid_q || pop)) begin
      // Short words arrive in the top of the shift register; right-align them.
      rx_data_d  = shift_q >> (3'd7 - CFG_TARGET_BITS);
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_i;
      rxs_q        <= rx_meta_q;
      rxs_prev_q   <= rxs_q;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_acc_q    <= par_acc_d;
      par_bad_q    <= par_bad_d;
      stop_bad_q   <= stop_bad_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign busy_o       = (state_q != StIdle);
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overrun_o    = overrun_q;

endmodule
